// File: rtl/isp_dma_pkg.sv
// rtl/isp_dma_pkg.sv - shared ISP DMA types and default widths
// Contents: sequencer state encoding; default widths shared with the read master.
package isp_dma_pkg;

  localparam int DEFAULT_ADDRESSWIDTH    = 30;
  localparam int DEFAULT_BYTEENABLEWIDTH = 4;
  localparam int DEFAULT_LINEW           = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/frame_read_sequencer_if.sv
// rtl/frame_read_sequencer_if.sv - control bus between frame sequencer and Avalon read master
// Signals:
//   rm_read_base    sequencer -> master  line start byte address
//   rm_read_length  sequencer -> master  line length in bytes
//   rm_go           sequencer -> master  1-cycle line launch
//   rm_done         master -> sequencer  all data of the issued transfer returned (level)
//   rm_early_done   master -> sequencer  master can accept the next go (level)
interface frame_read_sequencer_if
  import isp_dma_pkg::*;
#(
  parameter int AW = DEFAULT_ADDRESSWIDTH
);

  logic [AW-1:0] rm_read_base;
  logic [AW-1:0] rm_read_length;
  logic          rm_go;
  logic          rm_done;
  logic          rm_early_done;

  modport master (
    output rm_read_base,
    output rm_read_length,
    output rm_go,
    input  rm_done,
    input  rm_early_done
  );

  modport slave (
    input  rm_read_base,
    input  rm_read_length,
    input  rm_go,
    output rm_done,
    output rm_early_done
  );

endinterface

// File: rtl/frame_read_addr_gen.sv
// rtl/frame_read_addr_gen.sv - per-line address and index generator for the frame sequencer
// Ports:
//   clk, reset_n       clock, async active-low reset
//   load               latch base/stride/num_lines, restart at line 0
//   advance            step to next line (addr += stride, idx += 1)
//   base, stride       byte address of line 0, byte offset between lines
//   num_lines          lines in the frame
//   line_addr, idx     current line start address and index (registered)
//   last_line          idx is the final line of the frame
module frame_read_addr_gen
  import isp_dma_pkg::*;
#(
  parameter int AW    = DEFAULT_ADDRESSWIDTH,
  parameter int LINEW = DEFAULT_LINEW
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             advance,
  input  logic [AW-1:0]    base,
  input  logic [AW-1:0]    stride,
  input  logic [LINEW-1:0] num_lines,
  output logic [AW-1:0]    line_addr,
  output logic [LINEW-1:0] idx,
  output logic             last_line
);

  logic [AW-1:0]    stride_q;
  logic [LINEW-1:0] num_lines_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_addr   <= '0;
      idx         <= '0;
      stride_q    <= '0;
      num_lines_q <= '0;
    end else if (load) begin
      line_addr   <= base;
      idx         <= '0;
      stride_q    <= stride;
      num_lines_q <= num_lines;
    end else if (advance) begin
      // Wraps modulo 2^AW on purpose: frames may straddle the top of the address space.
      line_addr <= line_addr + stride_q;
      idx       <= idx + LINEW'(1);
    end
  end

  // num_lines_q is never 0 while a frame runs, so the subtraction cannot underflow in use.
  assign last_line = (idx == (num_lines_q - LINEW'(1)));

endmodule

// File: rtl/frame_read_sequencer.sv
// rtl/frame_read_sequencer.sv - sequences one Avalon read-master transfer per line over a 2-D frame
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   cfg_base/line_bytes/stride       frame geometry, latched on an accepted start
//   cfg_num_lines                    lines per frame
//   start, abort                     frame start request, stop after the current line
//   busy                             frame in progress
//   frame_done, aborted, cfg_error   1-cycle completion / abort / rejected-start pulses
//   line_start, line_index           pulse with rm_go, index of line last issued
//   rm                               read-master control bus (master side)
module frame_read_sequencer
  import isp_dma_pkg::*;
#(
  parameter int ADDRESSWIDTH    = DEFAULT_ADDRESSWIDTH,
  parameter int BYTEENABLEWIDTH = DEFAULT_BYTEENABLEWIDTH,
  parameter int LINEW           = DEFAULT_LINEW,
  parameter int USE_EARLY_DONE  = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDRESSWIDTH-1:0] cfg_base,
  input  logic [ADDRESSWIDTH-1:0] cfg_line_bytes,
  input  logic [ADDRESSWIDTH-1:0] cfg_stride,
  input  logic [LINEW-1:0]        cfg_num_lines,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    aborted,
  output logic                    cfg_error,
  output logic                    line_start,
  output logic [LINEW-1:0]        line_index,
  frame_read_sequencer_if.master  rm
);

  localparam int AW = ADDRESSWIDTH;

  state_t          state_q;
  state_t          state_d;
  logic            cfg_ok;
  logic            cond;
  logic            load;
  logic            advance;
  logic            reject;
  logic            finish;
  logic            last_line;
  logic            abort_pend_q;
  logic            rm_go_q;
  logic [AW-1:0]   line_bytes_q;
  logic [AW-1:0]   line_addr;

  frame_read_addr_gen #(
    .AW    (AW),
    .LINEW (LINEW)
  ) u_addr_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .advance   (advance),
    .base      (cfg_base),
    .stride    (cfg_stride),
    .num_lines (cfg_num_lines),
    .line_addr (line_addr),
    .idx       (line_index),
    .last_line (last_line)
  );

  assign cfg_ok = (cfg_line_bytes != '0)
               && ((cfg_line_bytes % AW'(BYTEENABLEWIDTH)) == '0)
               && (cfg_num_lines != '0);

  // Early-done lets the next line be issued while the previous one is still returning data.
  assign cond = (USE_EARLY_DONE != 0) ? rm.rm_early_done : rm.rm_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    reject  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            load    = 1'b1;
            state_d = ISSUE;
          end else begin
            reject = 1'b1;
          end
        end
      end
      // The master's done flags still describe the previous transfer during this
      // cycle, so they are deliberately not looked at here.
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (cond) begin
          if (last_line || abort_pend_q) begin
            state_d = DRAIN;
          end else begin
            advance = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      // Even in early-done mode the frame only completes once every byte is back.
      DRAIN: begin
        if (rm.rm_done) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rm_go_q      <= 1'b0;
      line_start   <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      aborted      <= 1'b0;
      cfg_error    <= 1'b0;
      abort_pend_q <= 1'b0;
      line_bytes_q <= '0;
    end else begin
      rm_go_q    <= (state_d == ISSUE);
      line_start <= (state_d == ISSUE);
      busy       <= (state_d != IDLE);
      frame_done <= finish && !abort_pend_q;
      aborted    <= finish && abort_pend_q;
      cfg_error  <= reject;
      if (load) begin
        line_bytes_q <= cfg_line_bytes;
      end
      // Posted reads cannot be cancelled, so abort only stops further lines.
      if (state_d == IDLE) begin
        abort_pend_q <= 1'b0;
      end else if (abort && (state_q != IDLE)) begin
        abort_pend_q <= 1'b1;
      end
    end
  end

  assign rm.rm_go          = rm_go_q;
  assign rm.rm_read_base   = line_addr;
  assign rm.rm_read_length = line_bytes_q;

endmodule
